// File: rtl/flash_playback_ctrl_if.sv
// Avalon-MM read port between the playback sequencer (master) and the flash controller (slave).
// A read is accepted on the first cycle where flash_read=1 and flash_waitrequest=0. Until then the
// master holds flash_read and flash_addr steady. Data returns later as a single-cycle flash_readdatavalid.
interface flash_playback_ctrl_if #(
  parameter int ADDR_W = 23
);
  logic              flash_read;
  logic [ADDR_W-1:0] flash_addr;
  logic              flash_waitrequest;
  logic              flash_readdatavalid;
  logic [31:0]       flash_readdata;

  modport master (
    output flash_read, flash_addr,
    input  flash_waitrequest, flash_readdatavalid, flash_readdata
  );

  modport slave (
    input  flash_read, flash_addr,
    output flash_waitrequest, flash_readdatavalid, flash_readdata
  );
endinterface

// File: rtl/flash_playback_ctrl.sv
// Flash audio playback sequencer: fetches 32-bit words, plays them as two 16-bit samples on sample_tick,
// walks the address forward/backward with wrap, and defers pause/restart until no flash read is in flight.
module flash_playback_ctrl #(
  parameter int                ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  cmd_start,
  input  logic                  cmd_pause,
  input  logic                  cmd_restart,
  input  logic                  direction,
  flash_playback_ctrl_if.master flash,
  output logic [15:0]           audio_sample,
  output logic                  audio_valid,
  output logic                  playing,
  output logic                  underrun,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_PAUSED, S_WAIT_T1, S_FETCH, S_WAIT_DV, S_EMIT1, S_WAIT_T2, S_EMIT2, S_ADVANCE
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx, reload, stepped;
  logic [31:0]       word_q;
  logic              dir_word;
  logic              pause_pend, pause_nx, restart_pend, restart_nx;
  logic              underrun_nx;
  logic [15:0]       sample_nx;
  logic              busy_pause, busy_restart;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_PAUSED;
      addr         <= '0;
      word_q       <= '0;
      dir_word     <= 1'b0;
      pause_pend   <= 1'b0;
      restart_pend <= 1'b0;
      underrun     <= 1'b0;
      audio_sample <= '0;
    end else begin
      state        <= state_nx;
      addr         <= addr_nx;
      pause_pend   <= pause_nx;
      restart_pend <= restart_nx;
      underrun     <= underrun_nx;
      audio_sample <= sample_nx;
      if (state == S_WAIT_DV && flash.flash_readdatavalid) begin
        word_q   <= flash.flash_readdata;
        dir_word <= direction;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    pause_nx     = 1'b0;
    restart_nx   = 1'b0;
    underrun_nx  = underrun;
    sample_nx    = audio_sample;
    reload       = direction ? '0 : MAX_ADDR;
    // A later start cancels a pause still waiting for the transaction to finish.
    busy_pause   = cmd_pause || (pause_pend && !cmd_start);
    busy_restart = cmd_restart || restart_pend;
    if (direction) stepped = (addr >= MAX_ADDR) ? '0 : addr + 1'b1;
    else           stepped = (addr == '0) ? MAX_ADDR : addr - 1'b1;

    case (state)
      S_PAUSED: begin
        if (cmd_restart) begin
          addr_nx     = reload;
          underrun_nx = 1'b0;
        end
        if (cmd_start && !cmd_pause) state_nx = S_WAIT_T1;
      end
      S_WAIT_T1: begin
        if (cmd_restart) begin
          addr_nx     = reload;
          underrun_nx = 1'b0;
        end
        if (cmd_pause)                        state_nx = S_PAUSED;
        else if (sample_tick && !cmd_restart) state_nx = S_FETCH;
      end
      S_FETCH: begin
        pause_nx   = busy_pause;
        restart_nx = busy_restart;
        if (sample_tick) underrun_nx = 1'b1;
        if (!flash.flash_waitrequest) state_nx = S_WAIT_DV;
      end
      S_WAIT_DV: begin
        pause_nx   = busy_pause;
        restart_nx = busy_restart;
        if (sample_tick) underrun_nx = 1'b1;
        if (flash.flash_readdatavalid) begin
          state_nx  = S_EMIT1;
          sample_nx = direction ? flash.flash_readdata[15:0] : flash.flash_readdata[31:16];
        end
      end
      S_EMIT1: begin
        if (busy_restart) begin
          addr_nx     = reload;
          underrun_nx = 1'b0;
        end
        if (busy_pause)        state_nx = S_PAUSED;
        else if (busy_restart) state_nx = S_WAIT_T1;
        else                   state_nx = S_WAIT_T2;
      end
      S_WAIT_T2: begin
        if (cmd_restart) begin
          addr_nx     = reload;
          underrun_nx = 1'b0;
        end
        if (cmd_pause)        state_nx = S_PAUSED;
        else if (cmd_restart) state_nx = S_WAIT_T1;
        else if (sample_tick) begin
          state_nx  = S_EMIT2;
          sample_nx = dir_word ? word_q[31:16] : word_q[15:0];
        end
      end
      S_EMIT2: begin
        pause_nx   = busy_pause;
        restart_nx = busy_restart;
        state_nx   = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (busy_restart) begin
          addr_nx     = reload;
          underrun_nx = 1'b0;
        end else begin
          addr_nx     = stepped;
        end
        state_nx = busy_pause ? S_PAUSED : S_WAIT_T1;
      end
      default: state_nx = S_PAUSED;
    endcase
  end

  assign flash.flash_read = (state == S_FETCH);
  assign flash.flash_addr = addr;
  assign audio_valid      = (state == S_EMIT1) || (state == S_EMIT2);
  assign playing          = (state != S_PAUSED);
  assign state_dbg        = state;

endmodule

// File: tb/tb_flash_playback_ctrl.sv
// Bench for flash_playback_ctrl: flash responder, tick/command driver and a scoreboard of expected
// fetch addresses and audio samples derived from the playback rules.
`timescale 1ns/1ps
module tb_flash_playback_ctrl;
  localparam int                ADDR_W   = 23;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 23'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_tick = 1'b0;
  logic        cmd_start = 1'b0;
  logic        cmd_pause = 1'b0;
  logic        cmd_restart = 1'b0;
  logic        direction = 1'b1;
  logic [15:0] audio_sample;
  logic        audio_valid;
  logic        playing;
  logic        underrun;
  logic [2:0]  state_dbg;

  flash_playback_ctrl_if #(.ADDR_W(ADDR_W)) flash ();

  flash_playback_ctrl #(.ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .cmd_start(cmd_start),
    .cmd_pause(cmd_pause), .cmd_restart(cmd_restart), .direction(direction),
    .flash(flash), .audio_sample(audio_sample), .audio_valid(audio_valid),
    .playing(playing), .underrun(underrun), .state_dbg(state_dbg)
  );

  // clock / reset
  always #10 clk = ~clk;

  int               n_cmp = 0;
  int               n_bad = 0;
  int               n_wait = 3;
  int               tick_cnt = 0;
  logic             tick_en = 1'b0;
  time              last_tick_time = 0;
  time              last_dv_time = 0;
  logic [15:0]      exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [15:0]      obs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
    sample_tick = 1'b0;
    cmd_start   = 1'b0;
    cmd_pause   = 1'b0;
    cmd_restart = 1'b0;
    if (tick_en) begin
      tick_cnt++;
      if (tick_cnt >= 20) begin
        tick_cnt       = 0;
        sample_tick    = 1'b1;
        last_tick_time = $time;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick_en = 1'b0;
    repeat (3) step();
    exp_q.delete();
    exp_addr_q.delete();
    obs.delete();
    tick_cnt = 0;
    step();
    rst = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int budget, input string name);
    int k = 0;
    while (obs.size() < n && k < budget) begin step(); k++; end
    if (obs.size() < n) fail_now(name);
  endtask

  task automatic wait_read(input int budget);
    int k = 0;
    while (!flash.flash_read && k < budget) begin step(); k++; end
    if (!flash.flash_read) fail_now("wait_read_timeout");
  endtask

  task automatic wait_paused(input int budget);
    int k = 0;
    while (playing && k < budget) begin step(); k++; end
    if (playing) fail_now("wait_paused_timeout");
  endtask

  task automatic pause_and_settle();
    step();
    cmd_pause = 1'b1;
    step();
    wait_paused(20);
  endtask

  task automatic push_word(input logic [ADDR_W-1:0] a, input logic fwd);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = a[15:0];
    hi = lo + 16'h0100;
    exp_addr_q.push_back(a);
    if (fwd) begin exp_q.push_back(lo); exp_q.push_back(hi); end
    else     begin exp_q.push_back(hi); exp_q.push_back(lo); end
  endtask

  // flash responder: n_wait waitrequest cycles, data two cycles after acceptance
  initial begin
    int          ws;
    int          dv_cnt;
    logic [15:0] a;
    logic [15:0] hi;
    ws = 0; dv_cnt = 0; a = '0;
    flash.flash_waitrequest   = 1'b1;
    flash.flash_readdatavalid = 1'b0;
    flash.flash_readdata      = '0;
    forever begin
      @(negedge clk);
      flash.flash_readdatavalid = 1'b0;
      if (!rst) begin
        ws = 0; dv_cnt = 0;
        flash.flash_waitrequest = 1'b1;
        continue;
      end
      if (dv_cnt > 0) begin
        dv_cnt--;
        if (dv_cnt == 0) begin
          hi = a + 16'h0100;
          flash.flash_readdatavalid = 1'b1;
          flash.flash_readdata      = {hi, a};
          last_dv_time              = $time;
        end
      end
      if (flash.flash_read) begin
        if (ws < n_wait) begin
          ws++;
          flash.flash_waitrequest = 1'b1;
        end else begin
          ws = 0;
          flash.flash_waitrequest = 1'b0;
          a      = flash.flash_addr[15:0];
          dv_cnt = 2;
        end
      end else begin
        ws = 0;
        flash.flash_waitrequest = 1'b1;
      end
    end
  end

  // scoreboard: every emitted sample and every new fetch address against the expected queues
  initial begin
    logic              prev_read;
    logic [ADDR_W-1:0] held_addr;
    logic [15:0]       e;
    logic [ADDR_W-1:0] ea;
    prev_read = 1'b0;
    held_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_read = 1'b0;
        continue;
      end
      if (audio_valid) begin
        obs.push_back(audio_sample);
        if (exp_q.size() == 0) fail_now("audio_unexpected");
        else begin
          e = exp_q.pop_front();
          check("audio_sample", {16'h0, audio_sample}, {16'h0, e});
        end
        check("audio_latency",
              {31'h0, ($time - last_dv_time == 20) || ($time - last_tick_time == 20)}, 32'd1);
      end
      if (flash.flash_read && !prev_read) begin
        held_addr = flash.flash_addr;
        if (exp_addr_q.size() == 0) fail_now("fetch_unexpected");
        else begin
          ea = exp_addr_q.pop_front();
          check("fetch_addr", 32'(flash.flash_addr), 32'(ea));
        end
      end else if (flash.flash_read) begin
        check("addr_hold", 32'(flash.flash_addr), 32'(held_addr));
      end
      prev_read = flash.flash_read;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // directed scenarios
  initial begin
    // forward playback with wrap after MAX_ADDR
    do_reset();
    check("rst_flash_read", 32'(flash.flash_read), 32'd0);
    check("rst_audio_valid", 32'(audio_valid), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_addr", 32'(flash.flash_addr), 32'd0);
    check("rst_sample", 32'(audio_sample), 32'd0);
    direction = 1'b1;
    for (int i = 0; i < 13; i++) push_word(ADDR_W'(i % 11), 1'b1);
    tick_en = 1'b1;
    cmd_start = 1'b1;
    step();
    wait_obs(26, 1500, "fwd_samples_timeout");
    pause_and_settle();
    check("fwd_final_addr", 32'(flash.flash_addr), 32'd2);
    check("fwd_paused", 32'(playing), 32'd0);
    check("fwd_obs1", 32'(obs[1]), 32'h0100);
    check("fwd_obs2", 32'(obs[2]), 32'h0001);
    check("fwd_obs21", 32'(obs[21]), 32'h010A);
    check("fwd_obs22", 32'(obs[22]), 32'h0000);
    check("fwd_drained", exp_q.size(), 32'd0);

    // async reset in the middle of a fetch
    exp_addr_q.push_back(ADDR_W'(2));
    cmd_start = 1'b1;
    step();
    wait_read(60);
    #2 rst = 1'b0;
    #1;
    check("arst_flash_read", 32'(flash.flash_read), 32'd0);
    check("arst_audio_valid", 32'(audio_valid), 32'd0);
    check("arst_playing", 32'(playing), 32'd0);
    check("arst_sample", 32'(audio_sample), 32'd0);
    check("arst_addr", 32'(flash.flash_addr), 32'd0);
    check("arst_underrun", 32'(underrun), 32'd0);

    // backward playback from reset: 0 wraps to MAX_ADDR, upper half first
    do_reset();
    direction = 1'b0;
    push_word(ADDR_W'(0), 1'b0);
    push_word(ADDR_W'(10), 1'b0);
    push_word(ADDR_W'(9), 1'b0);
    push_word(ADDR_W'(8), 1'b0);
    tick_en = 1'b1;
    cmd_start = 1'b1;
    step();
    wait_obs(8, 800, "bwd_samples_timeout");
    pause_and_settle();
    check("bwd_final_addr", 32'(flash.flash_addr), 32'd7);
    check("bwd_obs0", 32'(obs[0]), 32'h0100);
    check("bwd_obs2", 32'(obs[2]), 32'h010A);
    check("bwd_obs3", 32'(obs[3]), 32'h000A);
    check("bwd_drained", exp_q.size(), 32'd0);

    // pause while the read is stalled by waitrequest
    do_reset();
    direction = 1'b1;
    n_wait = 8;
    exp_addr_q.push_back(ADDR_W'(0));
    exp_q.push_back(16'h0000);
    tick_en = 1'b1;
    cmd_start = 1'b1;
    step();
    wait_read(60);
    cmd_pause = 1'b1;
    step();
    check("pause_read_held", 32'(flash.flash_read), 32'd1);
    check("pause_still_playing", 32'(playing), 32'd1);
    wait_paused(100);
    check("pause_addr", 32'(flash.flash_addr), 32'd0);
    check("pause_one_sample", obs.size(), 32'd1);
    n_wait = 3;
    push_word(ADDR_W'(0), 1'b1);
    cmd_start = 1'b1;
    step();
    check("resume_playing", 32'(playing), 32'd1);
    wait_obs(3, 200, "resume_timeout");
    pause_and_settle();
    check("resume_addr", 32'(flash.flash_addr), 32'd1);
    check("pause_drained", exp_q.size(), 32'd0);

    // stray tick during WAIT_DV, then restart backward from WAIT_T2 at addr 4
    do_reset();
    direction = 1'b1;
    for (int i = 0; i < 4; i++) push_word(ADDR_W'(i), 1'b1);
    exp_addr_q.push_back(ADDR_W'(4));
    exp_q.push_back(16'h0004);
    tick_en = 1'b1;
    cmd_start = 1'b1;
    step();
    wait_obs(4, 200, "pre_stray_timeout");
    wait_read(60);
    begin
      int k = 0;
      while (flash.flash_read && k < 40) begin step(); k++; end
    end
    sample_tick = 1'b1;
    step();
    check("underrun_set", 32'(underrun), 32'd1);
    wait_obs(9, 400, "pre_restart_timeout");
    step();
    check("underrun_sticky", 32'(underrun), 32'd1);
    check("restart_pre_addr", 32'(flash.flash_addr), 32'd4);
    check("restart_pre_count", obs.size(), 32'd9);
    direction = 1'b0;
    cmd_restart = 1'b1;
    step();
    check("restart_addr", 32'(flash.flash_addr), 32'd10);
    check("restart_underrun_clr", 32'(underrun), 32'd0);
    check("restart_playing", 32'(playing), 32'd1);
    push_word(ADDR_W'(10), 1'b0);
    wait_obs(11, 200, "post_restart_timeout");
    pause_and_settle();
    check("restart_final_addr", 32'(flash.flash_addr), 32'd9);
    check("restart_obs9", 32'(obs[9]), 32'h010A);
    check("restart_drained", exp_q.size(), 32'd0);
    check("restart_addr_drained", exp_addr_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
